// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - fetch buffer of {pc, inst} entries with flush and registered head
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [CW-1:0] count_o,
    output logic          valid_o,
    output fetch_entry_t  head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          pop_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign count_o = count_q;
    assign valid_o = (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Flush wins over push: a word returning during a redirect is stale by definition.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (push_i && !flush_i && !pop_ok) |-> (count_q < CW'(DEPTH)));

endmodule

// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: one outstanding imem read, buffered {pc, inst} to decode
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid_o,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_data_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_inst_o,
    input  logic        out_ready_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e        state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   req_pc_q;
    logic          drop_q;
    logic [CW-1:0] count;
    logic          fifo_valid;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          req_hs;
    logic          push;
    logic          pop;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    assign imem_req_valid_o = !rst && (state_q == S_REQ) && (count < CW'(DEPTH));
    assign imem_req_addr_o  = fetch_pc_q;
    assign req_hs           = imem_req_valid_o && imem_req_ready_i;

    assign push      = (state_q == S_WAIT) && imem_resp_valid_i && !drop_q && !redirect_valid_i;
    assign pop       = fifo_valid && out_ready_i;
    assign push_data = '{pc: req_pc_q, inst: imem_resp_data_i};

    // A redirect never cancels an accepted request; drop_q swallows its response instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            drop_q     <= 1'b0;
        end else if (redirect_valid_i) begin
            fetch_pc_q <= {redirect_pc_i[31:2], 2'b00};
            case (state_q)
                S_REQ: begin
                    if (req_hs) begin
                        state_q <= S_WAIT;
                        drop_q  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid_i) begin
                        state_q <= S_REQ;
                        drop_q  <= 1'b0;
                    end else begin
                        drop_q  <= 1'b1;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_hs) begin
                        req_pc_q   <= fetch_pc_q;
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid_i) begin
                        drop_q  <= 1'b0;
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    ifu_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (redirect_valid_i),
        .count_o     (count),
        .valid_o     (fifo_valid),
        .head_o      (head)
    );

    assign out_valid_o = fifo_valid;
    assign out_pc_o    = head.pc;
    assign out_inst_o  = head.inst;

    a_no_stray_resp: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid_i |-> (state_q == S_WAIT));

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - directed self-checking bench for ifu
module tb_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b1;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] XK = 32'hA5A5_A5A5;

    always #5 clk = ~clk;

    ifu dut (
        .clk               (clk),
        .rst               (rst),
        .imem_req_valid_o  (req_valid),
        .imem_req_addr_o   (req_addr),
        .imem_req_ready_i  (req_ready),
        .imem_resp_valid_i (resp_valid),
        .imem_resp_data_i  (resp_data),
        .redirect_valid_i  (redirect),
        .redirect_pc_i     (redirect_pc),
        .out_valid_o       (out_valid),
        .out_pc_o          (out_pc),
        .out_inst_o        (out_inst),
        .out_ready_i       (out_ready)
    );

    // Memory model: answers each accepted request mem_lat cycles later with addr ^ XK.
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_cnt = 0;
    int          mem_lat = 1;

    assign resp_valid = pend && (pend_cnt == 0);
    assign resp_data  = pend_addr ^ XK;

    always @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
        end else if (req_valid && req_ready) begin
            pend      <= 1'b1;
            pend_addr <= req_addr;
            pend_cnt  <= mem_lat - 1;
        end else if (pend) begin
            if (pend_cnt == 0) pend <= 1'b0;
            else pend_cnt <= pend_cnt - 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
        out_ready = 1'b1; req_ready = 1'b1; mem_lat = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
        checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_out_inst: got %h expected 0", out_inst); end
        rst = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b expected 1", req_valid); end
        checks++; if (req_addr !== 32'h8000_0000) begin errors++; $display("FAIL first_req_addr: got %h expected 80000000", req_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        int n;
        int last;
        exp_pc = 32'h8000_0000;
        n = 0;
        last = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(negedge clk);
            if (out_valid) begin
                checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL stream_pc%0d: got %h expected %h", n, out_pc, exp_pc); end
                checks++; if (out_inst !== (exp_pc ^ XK)) begin errors++; $display("FAIL stream_inst%0d: got %h expected %h", n, out_inst, exp_pc ^ XK); end
                checks++;
                if (n == 0 && c != 1) begin errors++; $display("FAIL stream_latency: got cycle %0d expected 1", c); end
                else if (n > 0 && (c - last) != 2) begin errors++; $display("FAIL stream_spacing%0d: got %0d expected 2", n, c - last); end
                last = c;
                n++;
                exp_pc = exp_pc + 32'd4;
            end
        end
        checks++; if (n != 3) begin errors++; $display("FAIL stream_timeout: got %0d outputs expected 3", n); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        int n;
        do_reset();
        out_ready = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
        checks++; if (out_pc !== 32'h8000_0000) begin errors++; $display("FAIL bp_head_pc: got %h expected 80000000", out_pc); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid_full: got %b expected 0", req_valid); end
        out_ready = 1'b1;
        exp_pc = 32'h8000_0000;
        n = 0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            if (out_valid) begin
                checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL bp_drain_pc%0d: got %h expected %h", n, out_pc, exp_pc); end
                if (n == 1) begin
                    checks++; if (c != 1) begin errors++; $display("FAIL bp_two_buffered: got cycle %0d expected 1", c); end
                end
                n++;
                exp_pc = exp_pc + 32'd4;
            end
            @(negedge clk);
        end
        checks++; if (n != 4) begin errors++; $display("FAIL bp_timeout: got %0d outputs expected 4", n); end
    endtask

    task automatic test_req_stall();
        bit seen;
        do_reset();
        req_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000) begin
                errors++; $display("FAIL stall_hold%0d: got valid %b addr %h expected 1 80000000", c, req_valid, req_addr);
            end
        end
        req_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                checks++; if (out_pc !== 32'h8000_0000) begin errors++; $display("FAIL stall_out_pc: got %h expected 80000000", out_pc); end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL stall_timeout: no output"); end
    endtask

    task automatic test_redirect_wait();
        bit req_seen;
        bit out_seen;
        do_reset();
        mem_lat = 3;
        @(negedge clk);
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rw_wait_req_valid: got %b expected 0", req_valid); end
        redirect = 1'b1;
        redirect_pc = 32'h8000_1003;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rw_out_valid: got %b expected 0", out_valid); end
        req_seen = 1'b0;
        out_seen = 1'b0;
        for (int c = 0; c < 20 && !out_seen; c++) begin
            if (req_valid && !req_seen) begin
                req_seen = 1'b1;
                checks++; if (req_addr !== 32'h8000_1000) begin errors++; $display("FAIL rw_next_addr: got %h expected 80001000", req_addr); end
                checks++; if (c != 2) begin errors++; $display("FAIL rw_req_cycle: got %0d expected 2", c); end
            end
            if (out_valid) begin
                out_seen = 1'b1;
                checks++; if (out_pc !== 32'h8000_1000) begin errors++; $display("FAIL rw_first_pc: got %h expected 80001000", out_pc); end
                checks++; if (out_inst !== (32'h8000_1000 ^ XK)) begin errors++; $display("FAIL rw_first_inst: got %h expected %h", out_inst, 32'h8000_1000 ^ XK); end
            end
            @(negedge clk);
        end
        checks++; if (!out_seen || !req_seen) begin errors++; $display("FAIL rw_timeout: req %b out %b expected 1 1", req_seen, out_seen); end
    endtask

    task automatic test_redirect_hs();
        bit out_seen;
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'h8000_3000;
        @(negedge clk);
        redirect_pc = 32'h8000_2000;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rh_out_valid: got %b expected 0", out_valid); end
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_2000) begin
            errors++; $display("FAIL rh_req: got valid %b addr %h expected 1 80002000", req_valid, req_addr);
        end
        out_seen = 1'b0;
        for (int c = 0; c < 20 && !out_seen; c++) begin
            @(negedge clk);
            if (out_valid) begin
                out_seen = 1'b1;
                checks++; if (out_pc !== 32'h8000_2000) begin errors++; $display("FAIL rh_first_pc: got %h expected 80002000", out_pc); end
                checks++; if (out_inst !== (32'h8000_2000 ^ XK)) begin errors++; $display("FAIL rh_first_inst: got %h expected %h", out_inst, 32'h8000_2000 ^ XK); end
            end
        end
        checks++; if (!out_seen) begin errors++; $display("FAIL rh_timeout: no output"); end
    endtask

    task automatic test_redirect_pop_wrap();
        logic [31:0] exp_pc;
        int n;
        do_reset();
        out_ready = 1'b0;
        repeat (10) @(negedge clk);
        out_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rp_out_valid: got %b expected 0", out_valid); end
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL rp_req: got valid %b addr %h expected 1 fffffffc", req_valid, req_addr);
        end
        exp_pc = 32'hFFFF_FFFC;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(negedge clk);
            if (out_valid) begin
                checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL rp_wrap_pc%0d: got %h expected %h", n, out_pc, exp_pc); end
                checks++; if (out_inst !== (exp_pc ^ XK)) begin errors++; $display("FAIL rp_wrap_inst%0d: got %h expected %h", n, out_inst, exp_pc ^ XK); end
                n++;
                exp_pc = exp_pc + 32'd4;
            end
        end
        checks++; if (n != 2) begin errors++; $display("FAIL rp_timeout: got %0d outputs expected 2", n); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_req_stall();
        test_redirect_wait();
        test_redirect_hs();
        test_redirect_pop_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit sitting directly upstream of the single-cycle core's decode stage. Owns the fetch PC, issues one instruction-memory read at a time over a valid/ready request channel, and buffers returned words with their PCs in a small FIFO. Decode consumes `{pc, inst}` pairs over a valid/ready handshake. A redirect input (branch/jump/trap) flushes all buffered and in-flight fetches.

## Interface
- `RESET_PC`, default `32'h8000_0000`: fetch PC loaded on reset.
- `DEPTH`, default `2`: fetch buffer entries, power of two, ≥2.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_req_valid`  out  1  read request pending.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_resp_valid`  in  1  read data valid; no backpressure, in order.
- `imem_resp_data`  in  32  instruction word.
- `redirect_valid`  in  1  flush and restart fetch.
- `redirect_pc`  in  32  new fetch PC; bits [1:0] ignored, treated as 0.
- `out_valid`  out  1  buffer head valid.
- `out_pc`  out  32  PC of head entry.
- `out_inst`  out  32  instruction of head entry.
- `out_ready`  in  1  decode consumes head.

## Operation
- Registers: `fetch_pc`, `req_pc`, FSM state, `drop` flag, FIFO (`count`, rd/wr pointers, storage).
- FSM `S_REQ`: `imem_req_valid = (count < DEPTH)`. On `imem_req_valid && imem_req_ready`, set `req_pc ← fetch_pc`, `fetch_pc ← fetch_pc + 4` (mod 2^32, wraps), go to `S_WAIT`.
- FSM `S_WAIT`: `imem_req_valid = 0`. On `imem_resp_valid`: if `!drop`, push `{req_pc, imem_resp_data}`. Then clear `drop` and go to `S_REQ`.
- At most one outstanding request, so `count` never exceeds `DEPTH`. A push is only possible when `count < DEPTH` held at request time; no overflow check needed, but assert it.
- Pop on `out_valid && out_ready`. Push and pop in the same cycle leave `count` unchanged.
- Redirect has the highest priority. It sets `fetch_pc ← {redirect_pc[31:2], 2'b00}` and empties the FIFO (`count ← 0`, pointers ← 0).
  - In `S_REQ` with no handshake: stay in `S_REQ`.
  - In `S_REQ` with a handshake in the same cycle: that request is outstanding. Go to `S_WAIT` with `drop ← 1`, and do not apply the `+4` update.
  - In `S_WAIT` without a response: set `drop ← 1`.
  - In `S_WAIT` with a response in the same cycle: discard the response, go to `S_REQ`, `drop ← 0`.
- Pop coinciding with redirect: decode's handshake completes and the entry counts as consumed. The flush still clears everything.
- Stray `imem_resp_valid` in `S_REQ` is ignored; flag with an assertion.
- Request stability: once `imem_req_valid` is high, it stays high with `imem_req_addr` constant until accepted. Only a redirect or `rst` may change the address or drop valid.
- `imem_req_addr = fetch_pc`.

## Timing
- Reset values:
  - `fetch_pc = RESET_PC`, state `S_REQ`, `drop = 0`, `count = 0`.
  - FIFO storage = 0, so `out_pc = out_inst = 0`.
  - `out_valid = 0`; `imem_req_valid = 0` while `rst` is high.
- First request: `imem_req_valid = 1`, addr `RESET_PC` in the first cycle after `rst` deasserts.
- Latency, zero-wait memory:
  - Request accepted in cycle N.
  - Response arrives in N+1.
  - `out_valid` rises in N+2.
  - Next request is issued in N+2.
- Peak throughput: one instruction per 2 cycles.
- Redirect in cycle N: `out_valid = 0` in N+1. The first request to the new PC appears in N+1 (from `S_REQ`), or the cycle after the pending response is dropped (from `S_WAIT`).
- `out_*` are registered (FIFO head); no combinational path from `imem_resp_*` to `out_*`.
- `rst` mid-fetch: the outstanding response is not tracked after reset. Memory is reset by the same `rst`.

## Structure
- Shared package `ifu_pkg`:
  - `RESET_PC_DEFAULT`.
  - State enum `{S_REQ, S_WAIT}`.
  - Packed struct `fetch_entry_t {pc[31:0], inst[31:0]}`.
- Sub-module `ifu_fifo`: synchronous FIFO of `fetch_entry_t`, `DEPTH` entries, with push/pop/flush, `count`, registered head. Flush has priority over push.

## Test plan
- Reset then zero-wait memory returning `inst = addr ^ 32'hA5A5A5A5`: out sequence PCs `80000000, 80000004, 80000008`, each with matching inst, one every 2 cycles.
- `out_ready = 0` for 10 cycles: exactly 2 entries buffered. `imem_req_valid` deasserts when `count = 2` in `S_REQ`. Releasing `out_ready` resumes in order with no loss or duplicate.
- `imem_req_ready` low for 5 cycles: `imem_req_valid` and `imem_req_addr` held constant.
- Redirect to `0x80001003` while in `S_WAIT`: the late response is dropped, the next request addr is `0x80001000`, and no stale PC appears on `out_*`.
- Redirect in the same cycle as a request handshake and then as a response: both responses are discarded, and the first output PC equals the redirect target.
- Redirect coinciding with a pop while full: `out_valid = 0` next cycle, `count = 0`. A fetch PC of `0xFFFFFFFC` wraps to `0x00000000`.
